// File: rtl/gate3_resp_checker_if.sv
`default_nettype none
// ============================================================================
// Module   : gate3_resp_checker_if
// Purpose  : Sample/handshake and scoreboard bundle for gate3_resp_checker.
// Revision : 1.0 - initial release
// ============================================================================
interface gate3_resp_checker_if #(
  parameter int ERR_W = 8,
  parameter int CNT_W = 8
);
  logic             start;
  logic             in_valid;
  logic             i1;
  logic             i2;
  logic             i3;
  logic             o;
  logic             in_ready;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [CNT_W-1:0] sample_count;
  logic [7:0]       covered;
  logic             first_fail_valid;
  logic [2:0]       first_fail_vec;

  // Stimulus side: drives vectors and the observed gate output.
  modport master (
    output start, in_valid, i1, i2, i3, o,
    input  in_ready, busy, done, pass, err_count, sample_count, covered,
           first_fail_valid, first_fail_vec
  );

  modport slave (
    input  start, in_valid, i1, i2, i3, o,
    output in_ready, busy, done, pass, err_count, sample_count, covered,
           first_fail_valid, first_fail_vec
  );
endinterface
`default_nettype wire

// File: rtl/gate3_resp_checker.sv
`default_nettype none
// ============================================================================
// Module   : gate3_resp_checker
// Purpose  : Truth-table response checker with coverage for AND3/OR3 family.
// Revision : 1.0 - initial release
// ============================================================================
module gate3_resp_checker #(
  parameter int GATE_FN = 0,
  parameter int ERR_W   = 8,
  parameter int CNT_W   = 8
) (
  input  wire logic          clk,
  input  wire logic          rst,
  gate3_resp_checker_if.slave bus
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DONE   = 2'd2
  } state_t;

  localparam logic [ERR_W-1:0] c_err_one = {{(ERR_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic [ERR_W-1:0] err_count_q, err_count_d;
  logic [CNT_W-1:0] sample_count_q, sample_count_d;
  logic [7:0]       covered_q, covered_d;
  logic             first_fail_valid_q, first_fail_valid_d;
  logic [2:0]       first_fail_vec_q, first_fail_vec_d;
  logic             pass_q, pass_d;

  logic [2:0]       vec;
  logic             exp_o;

  assign vec = {bus.i3, bus.i2, bus.i1};

  // Unknown function codes fall back to AND3.
  always_comb begin
    case (GATE_FN)
      1:       exp_o = |vec;
      2:       exp_o = ~(&vec);
      3:       exp_o = ~(|vec);
      default: exp_o = &vec;
    endcase
  end

  always_comb begin
    state_d            = state_q;
    err_count_d        = err_count_q;
    sample_count_d     = sample_count_q;
    covered_d          = covered_q;
    first_fail_valid_d = first_fail_valid_q;
    first_fail_vec_d   = first_fail_vec_q;
    pass_d             = pass_q;

    // start opens a fresh session from any state and drops a same-cycle sample.
    if (bus.start) begin
      state_d            = S_ACTIVE;
      err_count_d        = '0;
      sample_count_d     = '0;
      covered_d          = '0;
      first_fail_valid_d = 1'b0;
      first_fail_vec_d   = 3'b000;
      pass_d             = 1'b0;
    end else begin
      case (state_q)
        S_ACTIVE: begin
          if (bus.in_valid) begin
            if (sample_count_q != '1) begin
              sample_count_d = sample_count_q + c_cnt_one;
            end
            covered_d = covered_q | (8'b0000_0001 << vec);
            if (bus.o != exp_o) begin
              if (err_count_q != '1) begin
                err_count_d = err_count_q + c_err_one;
              end
              if (!first_fail_valid_q) begin
                first_fail_valid_d = 1'b1;
                first_fail_vec_d   = vec;
              end
            end
            if (covered_d == 8'hFF) begin
              state_d = S_DONE;
              pass_d  = (err_count_d == '0);
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q            <= S_IDLE;
      err_count_q        <= '0;
      sample_count_q     <= '0;
      covered_q          <= '0;
      first_fail_valid_q <= 1'b0;
      first_fail_vec_q   <= 3'b000;
      pass_q             <= 1'b0;
    end else begin
      state_q            <= state_d;
      err_count_q        <= err_count_d;
      sample_count_q     <= sample_count_d;
      covered_q          <= covered_d;
      first_fail_valid_q <= first_fail_valid_d;
      first_fail_vec_q   <= first_fail_vec_d;
      pass_q             <= pass_d;
    end
  end

  assign bus.in_ready         = (state_q == S_ACTIVE);
  assign bus.busy             = (state_q == S_ACTIVE);
  assign bus.done             = (state_q == S_DONE);
  assign bus.pass             = pass_q;
  assign bus.err_count        = err_count_q;
  assign bus.sample_count     = sample_count_q;
  assign bus.covered          = covered_q;
  assign bus.first_fail_valid = first_fail_valid_q;
  assign bus.first_fail_vec   = first_fail_vec_q;

endmodule
`default_nettype wire

// File: doc/gate3_resp_checker.md
# gate3_resp_checker

Synthesizable response checker for the 3-input gate cells (AND3/OR3 family). It is the receiving end of the exhaustive-stimulus flow that drives i1/i2/i3 into a gate under test. The block observes each applied vector together with the gate's output `o`, compares `o` against the expected truth-table value, tracks which of the 8 input patterns have been seen, and reports a pass/fail verdict once all patterns are covered. It sits beside the DUV in on-chip self-test wrappers and in system-level benches.

## Interface
- GATE_FN, default 0: expected function. 0=AND3, 1=OR3, 2=NAND3, 3=NOR3. Any other value is treated as AND3.
- ERR_W, default 8: width of the saturating mismatch counter.
- CNT_W, default 8: width of the saturating accepted-sample counter.

- clk  in  1  single clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; clears the scoreboard and opens a session.
- in_valid  in  1  marks i1/i2/i3/o as a settled sample.
- i1, i2, i3  in  1 each  applied stimulus vector; vec = {i3,i2,i1}.
- o  in  1  observed gate output.
- in_ready  out  1  high while ACTIVE; a sample is accepted when in_valid & in_ready.
- busy  out  1  session in progress (ACTIVE).
- done  out  1  all 8 vectors covered; held until start or rst.
- pass  out  1  valid while done; 1 iff err_count==0.
- err_count  out  ERR_W  mismatches in the session; saturates at all-ones.
- sample_count  out  CNT_W  accepted samples; saturates at all-ones.
- covered  out  8  bit k set once vec==k has been accepted.
- first_fail_valid  out  1  at least one mismatch has occurred in the session.
- first_fail_vec  out  3  vec of the first mismatching sample.

## Operation
- States: IDLE, ACTIVE, DONE.
- IDLE: in_ready=0, in_valid is ignored. On start, go to ACTIVE and clear err_count, sample_count, covered, first_fail_*, pass and done.
- ACTIVE: on each accepted sample:
  - Compute exp from vec per GATE_FN.
  - Increment sample_count (saturating) and set covered[vec].
  - If o != exp: increment err_count (saturating). If first_fail_valid==0, latch first_fail_vec=vec and set first_fail_valid.
- ACTIVE→DONE when the updated covered equals 8'hFF, including the covering sample itself. On entry, pass = (updated err_count==0) and done=1.
- DONE: in_ready=0 and samples are ignored. Outputs hold until start (restart the session, same as from IDLE) or rst.
- start while ACTIVE aborts and restarts: counters clear and any in_valid in the same cycle is discarded (start wins).
- Duplicate vectors are compared and counted. They do not change coverage.
- Saturated counters stay at all-ones. Comparison and coverage continue.

## Timing
- Reset: state IDLE. in_ready, busy, done, pass, first_fail_valid = 0. err_count, sample_count, covered = 0. first_fail_vec = 3'b000.
- rst takes priority over start and in_valid. Reset mid-session discards all progress at the next edge.
- in_ready and busy are decoded from the state register, so they go high the cycle after start is sampled.
- Scoreboard outputs are registered: they update on the edge that accepts a sample and are visible the following cycle.
- done and pass assert in the cycle after the final covering sample is accepted. in_ready drops in that same cycle.
- There is no back-pressure beyond state: throughput is one sample per cycle while ACTIVE.

## Test plan
- GATE_FN=0, start, apply vec 0..7 with correct AND outputs (o=1 only at 7), one per cycle → done=1 and pass=1 one cycle after vec 7; err_count=0, sample_count=8, covered=8'hFF.
- GATE_FN=1, apply vec 0..7 with o forced 1 at vec 0 and 0 at vec 5 → err_count=2, first_fail_valid=1, first_fail_vec=3'b000, done=1, pass=0.
- GATE_FN=0, apply vec 0 three times, then vec 1..7 → sample_count=10; done stays 0 until vec 7 is accepted; covered=8'hFF; pass=1.
- ERR_W=2, GATE_FN=3, apply 5 wrong samples on vec 0, then vec 1..7 correct → err_count=3 (saturated), pass=0.
- Accept 4 samples, then assert rst for one cycle with in_valid held high → next cycle all outputs at reset values, in_ready=0, no further acceptance until start.
- While ACTIVE with 3 samples accepted, pulse start together with in_valid=1 → that sample is discarded, and next cycle sample_count=0, covered=0, busy=1.
